// File: rtl/display_mode_scheduler.sv
// Display mode scheduler: picks which mode datapath owns the 2x16 LCD
// (mode button, alarm override, idle timeout). It snapshots that mode's two
// text lines on a refresh schedule or whenever the shown mode changes.
// Each snapshot is offered to the LCD driver over a valid/ready handshake,
// and the offered lines stay frozen until the driver accepts them.
module display_mode_scheduler #(
  parameter int NUM_MODES  = 4,
  parameter int ALARM_MODE = 3,
  parameter int REFRESH_MS = 100,
  parameter int TIMEOUT_MS = 10000
) (
  input  logic         clk_1kHz,
  input  logic         i_rst_n,
  input  logic         i_btn_mode,
  input  logic         i_alarm_req,
  input  logic [511:0] i_mode_line1,
  input  logic [511:0] i_mode_line2,
  input  logic         i_lcd_ready,
  output logic [1:0]   o_mode,
  output logic [127:0] o_line1,
  output logic [127:0] o_line2,
  output logic         o_lcd_valid
);

  localparam int REF_W = (REFRESH_MS > 1) ? $clog2(REFRESH_MS) : 1;
  localparam int TMO_W = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_MS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_MS - 1);
  localparam logic [1:0]       MODE_LAST  = 2'(NUM_MODES - 1);
  localparam logic [1:0]       ALARM_IDX  = 2'(ALARM_MODE);
  localparam logic [127:0]     BLANK_LINE = {16{8'h20}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_OFFER = 2'd2
  } state_e;

  // Registered state
  state_e             state_q, state_d;
  logic               btn_q;
  logic               alarm_q;
  logic [1:0]         user_mode_q, user_mode_d;
  logic [1:0]         mode_q, mode_d;
  logic [REF_W-1:0]   refresh_q, refresh_d;
  logic [TMO_W-1:0]   timeout_q, timeout_d;
  logic               pending_q, pending_d;
  logic               lcd_valid_q, lcd_valid_d;
  logic [127:0]       line1_q, line1_d;
  logic [127:0]       line2_q, line2_d;

  // Combinational helpers
  logic               press_s;
  logic               alarm_fall_s;
  logic               timeout_hit_s;
  logic               user_trig_s;
  logic               refresh_wrap_s;
  logic               trigger_s;
  logic               clear_pending_s;
  logic [127:0]       sel_line1_s;
  logic [127:0]       sel_line2_s;

  // A press is a rising level on the raw button; the alarm raw level gates it
  // so that an alarm arriving on the same edge as a press wins.
  assign press_s       = i_btn_mode & ~btn_q;
  assign alarm_fall_s  = alarm_q & ~i_alarm_req;
  assign timeout_hit_s = (user_mode_q != 2'd0) & ~i_alarm_req & (timeout_q == TMO_LAST);

  // User mode stepping and idle timeout; a press always beats a timeout
  always_comb begin
    user_mode_d = user_mode_q;
    timeout_d   = timeout_q;
    user_trig_s = 1'b0;
    if (press_s) begin
      timeout_d = '0;
      if (i_alarm_req) begin
        user_mode_d = user_mode_q;
      end else begin
        user_mode_d = (user_mode_q == MODE_LAST) ? 2'd0 : (user_mode_q + 2'd1);
        user_trig_s = 1'b1;
      end
    end else if (timeout_hit_s) begin
      user_mode_d = 2'd0;
      timeout_d   = '0;
      user_trig_s = 1'b1;
    end else if (user_mode_q == 2'd0) begin
      timeout_d = '0;
    end else if (!i_alarm_req) begin
      timeout_d = timeout_q + TMO_W'(1);
    end else begin
      // alarm active: idle count is paused, not cleared
      timeout_d = timeout_q;
    end
  end

  // Displayed mode follows the registered alarm level, otherwise the user mode
  always_comb begin
    if (alarm_q) begin
      mode_d = ALARM_IDX;
    end else begin
      mode_d = user_mode_q;
    end
  end

  // Free-running refresh divider; its wrap requests a periodic snapshot
  always_comb begin
    refresh_wrap_s = (refresh_q == REF_LAST);
    if (refresh_wrap_s) begin
      refresh_d = '0;
    end else begin
      refresh_d = refresh_q + REF_W'(1);
    end
  end

  // Any reason to redraw collapses into the single pending flag
  assign trigger_s = user_trig_s | alarm_fall_s | (mode_d != mode_q) | refresh_wrap_s;

  // Line pair of the currently displayed mode
  always_comb begin
    case (mode_q)
      2'd0:    begin sel_line1_s = i_mode_line1[127:0];   sel_line2_s = i_mode_line2[127:0];   end
      2'd1:    begin sel_line1_s = i_mode_line1[255:128]; sel_line2_s = i_mode_line2[255:128]; end
      2'd2:    begin sel_line1_s = i_mode_line1[383:256]; sel_line2_s = i_mode_line2[383:256]; end
      2'd3:    begin sel_line1_s = i_mode_line1[511:384]; sel_line2_s = i_mode_line2[511:384]; end
      default: begin sel_line1_s = i_mode_line1[127:0];   sel_line2_s = i_mode_line2[127:0];   end
    endcase
  end

  // Snapshot FSM next state and registered handshake outputs
  always_comb begin
    state_d         = state_q;
    lcd_valid_d     = lcd_valid_q;
    line1_d         = line1_q;
    line2_d         = line2_q;
    clear_pending_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        line1_d         = sel_line1_s;
        line2_d         = sel_line2_s;
        lcd_valid_d     = 1'b1;
        clear_pending_s = 1'b1;
        state_d         = ST_OFFER;
      end
      ST_OFFER: begin
        if (lcd_valid_q && i_lcd_ready) begin
          lcd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_OFFER;
        end
      end
      default: begin
        lcd_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // A trigger in the same cycle as LOAD must survive the clear
  always_comb begin
    if (trigger_s) begin
      pending_d = 1'b1;
    end else if (clear_pending_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Input samplers, user/displayed mode and counters
  always_ff @(posedge clk_1kHz) begin
    if (!i_rst_n) begin
      btn_q       <= 1'b0;
      alarm_q     <= 1'b0;
      user_mode_q <= 2'd0;
      mode_q      <= 2'd0;
      refresh_q   <= '0;
      timeout_q   <= '0;
    end else begin
      btn_q       <= i_btn_mode;
      alarm_q     <= i_alarm_req;
      user_mode_q <= user_mode_d;
      mode_q      <= mode_d;
      refresh_q   <= refresh_d;
      timeout_q   <= timeout_d;
    end
  end

  // Snapshot FSM state, pending flag and offered snapshot
  always_ff @(posedge clk_1kHz) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b1;
      lcd_valid_q <= 1'b0;
      line1_q     <= BLANK_LINE;
      line2_q     <= BLANK_LINE;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      lcd_valid_q <= lcd_valid_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
    end
  end

  assign o_mode      = mode_q;
  assign o_line1     = line1_q;
  assign o_line2     = line2_q;
  assign o_lcd_valid = lcd_valid_q;

endmodule
